event_listener: RTL and testbench

Receive side of the named-event handshake: it detects one-cycle event strobes from a producer (a counter/sequencer that fires `ev_trig` at a threshold, e.g. count == 25). Each strobe's payload and timestamp are captured into a small FIFO and presented downstream on a valid/ready interface. Arm/disarm control and an optional one-shot mode are provided. Drops are counted.

---
 rtl/event_pkg.sv | 24 ++
 rtl/event_fifo.sv | 50 +++++
 rtl/event_listener.sv | 129 ++++++++++++
 tb/tb_event_listener.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// Shared types and constants for the event listener slice.
// Optional feature macro: EVENT_LISTENER_TSTAMP_EN (timestamp capture).
package event_pkg;

    // Listener arming state.
    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        DONE     = 2'd2
    } ev_state_t;

    localparam int              DROP_W   = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

    // Record layout at the default widths (payload above timestamp).
    localparam int EV_DATA_W = 8;
    localparam int EV_TS_W   = 16;

    typedef struct packed {
        logic [EV_DATA_W-1:0] data;
        logic [EV_TS_W-1:0]   ts;
    } ev_rec_t;

endpackage

// File: rtl/event_fifo.sv
// Parametric synchronous FIFO with extra-bit wrap pointers.
// Head is presented combinationally; reads as zero while empty.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer registers.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write port.
    // NOTE: storage has no reset; emptiness is tracked by the pointers alone, so old contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/event_listener.sv
// Event listener: arm/disarm/oneshot FSM, capture into a FIFO, drop counting.
// Optional feature macro: EVENT_LISTENER_TSTAMP_EN builds the timestamp
// counter and the per-entry timestamp field; otherwise out_ts is tied to 0.
module event_listener
    import event_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int TS_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              disarm,
    input  logic              oneshot,
    input  logic              ev_trig,
    input  logic [DATA_W-1:0] ev_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TS_W-1:0]   out_ts,
    output logic              armed,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              overflow,
    input  logic              clr
);

`ifdef EVENT_LISTENER_TSTAMP_EN
    localparam int REC_W = DATA_W + TS_W;
`else
    localparam int REC_W = DATA_W;
`endif

    ev_state_t        state_q, state_d;
    logic             os_q, os_d;
    logic             fifo_full, fifo_empty;
    logic             pop, accept, drop;
    logic [REC_W-1:0] push_rec, head_rec;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // State register and latched oneshot mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DISARMED;
            os_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            os_q    <= os_d;
        end
    end

    // Next-state logic: disarm has priority over arm and over the oneshot finish.
    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        os_d    = os_q;
        unique case (state_q)
            ARMED: begin
                if (disarm)             state_d = DISARMED;
                else if (accept && os_q) state_d = DONE;
            end
            DISARMED, DONE: begin
                if (disarm) begin
                    state_d = DISARMED;
                end else if (arm) begin
                    state_d = ARMED;
                    os_d    = oneshot;
                end
            end
            default: state_d = DISARMED;
        endcase
    end

    // Output decode: armed flag and capture arbitration against FIFO space.
    always_comb begin
        armed  = (state_q == ARMED);
        accept = armed && ev_trig && (!fifo_full || pop);
        drop   = armed && ev_trig && fifo_full && !pop;
    end

    // Saturating drop counter and sticky overflow; clear beats a coincident drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else if (drop) begin
            if (drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
            overflow <= 1'b1;
        end
    end

`ifdef EVENT_LISTENER_TSTAMP_EN
    logic [TS_W-1:0] ts_q;

    // Free-running timestamp; a capture stores the value before its edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts_q <= '0;
        else     ts_q <= ts_q + 1'b1;
    end

    assign push_rec = {ev_data, ts_q};
    assign out_data = head_rec[REC_W-1 -: DATA_W];
    assign out_ts   = head_rec[TS_W-1:0];
`else
    assign push_rec = ev_data;
    assign out_data = head_rec;
    assign out_ts   = '0;
`endif

    event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .wr_data (push_rec),
        .pop     (pop),
        .rd_data (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_event_listener.sv
// Bench for event_listener: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_event_listener;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int TS_W   = 16;
    localparam int M_DIS  = 0;
    localparam int M_ARM  = 1;
    localparam int M_DONE = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              arm = 1'b0, disarm = 1'b0, oneshot = 1'b0;
    logic              ev_trig = 1'b0;
    logic [DATA_W-1:0] ev_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;
    logic              armed;
    logic [7:0]        drop_cnt;
    logic              overflow;
    logic              clr = 1'b0;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    event_listener #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .arm       (arm),
        .disarm    (disarm),
        .oneshot   (oneshot),
        .ev_trig   (ev_trig),
        .ev_data   (ev_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ts    (out_ts),
        .armed     (armed),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow),
        .clr       (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int data;
        int ts;
    } rec_t;

    rec_t q[$];
    int   m_st  = M_DIS;
    bit   m_os  = 0;
    int   m_cnt = 0;
    bit   m_ov  = 0;
    int   m_ts  = 0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_st = M_DIS; m_os = 0; m_cnt = 0; m_ov = 0; m_ts = 0;
                edge_cnt = 0;
            end else begin
                bit   pop_now, acc, drp;
                rec_t r;
                pop_now = (q.size() != 0) && out_ready;
                acc = 0;
                drp = 0;
                if (m_st == M_ARM && ev_trig) begin
                    if (q.size() < DEPTH || pop_now) acc = 1;
                    else                             drp = 1;
                end
                if (pop_now) void'(q.pop_front());
                if (acc) begin
                    r.data = ev_data;
`ifdef EVENT_LISTENER_TSTAMP_EN
                    r.ts = m_ts;
`else
                    r.ts = 0;
`endif
                    q.push_back(r);
                end
                if (clr) begin
                    m_cnt = 0;
                    m_ov  = 0;
                end else if (drp) begin
                    if (m_cnt < 255) m_cnt++;
                    m_ov = 1;
                end
                if (disarm) m_st = M_DIS;
                else if (m_st != M_ARM && arm) begin
                    m_st = M_ARM;
                    m_os = oneshot;
                end else if (m_st == M_ARM && acc && m_os) m_st = M_DONE;
                m_ts = (m_ts + 1) % (1 << TS_W);
                edge_cnt++;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("cmp_data", out_data, q[0].data);
                check("cmp_ts", out_ts, q[0].ts);
            end
            check("cmp_armed", armed, m_st == M_ARM);
            check("cmp_drop", drop_cnt, m_cnt);
            check("cmp_ovf", overflow, m_ov);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic event_pulse(input int d);
        ev_trig = 1'b1;
        ev_data = d[DATA_W-1:0];
        step();
        ev_trig = 1'b0;
    endtask

    int exp_seq [5] = '{1, 2, 3, 4, 9};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_ts", out_ts, 0);
        check("rst_armed", armed, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);

        // Continuous arm, single capture at ts 40
        arm = 1'b1; step(); arm = 1'b0;
        check("arm_armed", armed, 1);
        for (int i = 0; i < 100 && edge_cnt != 40; i++) step();
        check("ts40_reached", edge_cnt, 40);
        event_pulse(25);
        check("ev25_valid", out_valid, 1);
        check("ev25_data", out_data, 25);
`ifdef EVENT_LISTENER_TSTAMP_EN
        check("ev25_ts", out_ts, 40);
`else
        check("ev25_ts", out_ts, 0);
`endif
        check("ev25_armed", armed, 1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("ev25_popped", out_valid, 0);

        // Oneshot: only the first event is taken
        disarm = 1'b1; step(); disarm = 1'b0;
        oneshot = 1'b1; arm = 1'b1; step(); arm = 1'b0; oneshot = 1'b0;
        event_pulse(10);
        step();
        event_pulse(11);
        check("os_armed", armed, 0);
        check("os_drop", drop_cnt, 0);
        check("os_data", out_data, 10);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("os_only_one", out_valid, 0);

        // Overflow: 6 events into 4 entries
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 1; i <= 6; i++) event_pulse(i);
        check("ovf_drop", drop_cnt, 2);
        check("ovf_flag", overflow, 1);
        check("ovf_head", out_data, 1);

        // Full FIFO with simultaneous push (9) and pop, then drain in order
        for (int k = 0; k < 5; k++) begin
            out_ready = 1'b1;
            if (k == 0) begin
                ev_trig = 1'b1;
                ev_data = 8'd9;
            end
            check("drain_order", out_data, exp_seq[k]);
            step();
            ev_trig = 1'b0;
        end
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);
        check("pushpop_drop", drop_cnt, 2);

        // Clear
        clr = 1'b1; step(); clr = 1'b0;
        check("clr_drop", drop_cnt, 0);
        check("clr_ovf", overflow, 0);

        // Saturation after 300 drops
        for (int i = 0; i < 4; i++) event_pulse(100 + i);
        for (int i = 0; i < 300; i++) event_pulse(i & 8'hff);
        check("sat_drop", drop_cnt, 255);
        check("sat_ovf", overflow, 1);

        // Clear beats a coincident drop
        clr = 1'b1; ev_trig = 1'b1; ev_data = 8'd200; step();
        clr = 1'b0; ev_trig = 1'b0;
        check("clrwin_drop", drop_cnt, 0);
        check("clrwin_ovf", overflow, 0);
        check("clrwin_head", out_data, 100);

        // Reset mid-operation with 3 entries queued
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_armed", armed, 0);
        check("async_rst_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("post_rst_valid", out_valid, 0);

        // arm + disarm together: disarm wins
        arm = 1'b1; disarm = 1'b1; step(); arm = 1'b0; disarm = 1'b0;
        check("armdis_armed", armed, 0);

        // ev_trig with arm is ignored
        arm = 1'b1; ev_trig = 1'b1; ev_data = 8'd50; step();
        arm = 1'b0; ev_trig = 1'b0;
        check("evarm_armed", armed, 1);
        check("evarm_valid", out_valid, 0);

        // ev_trig with disarm while armed is captured
        disarm = 1'b1; ev_trig = 1'b1; ev_data = 8'd77; step();
        disarm = 1'b0; ev_trig = 1'b0;
        check("evdis_armed", armed, 0);
        check("evdis_valid", out_valid, 1);
        check("evdis_data", out_data, 77);
`ifndef EVENT_LISTENER_TSTAMP_EN
        check("evdis_ts_zero", out_ts, 0);
`endif

        // ev_trig while disarmed is neither captured nor dropped
        event_pulse(88);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("ignored_valid", out_valid, 0);
        check("ignored_drop", drop_cnt, 0);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
